control_sequencer: RTL and testbench

//  Multi-cycle control FSM sitting directly upstream of the ALU. Fetches

---
 rtl/control_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute controller that sits
// directly upstream of the ALU. Instructions are fetched over a req/ack
// memory handshake. The IR is decoded into an ALU operation, register
// load/increment strobes and a bus source select. The architectural zero
// flag is kept here, and JMPZ tests it.

module control_sequencer #(
    parameter int reg_width   = 12,  // datapath width, shared with the ALU
    parameter int INSTR_W     = 8,   // IR width: opcode [7:4], reg field [3:0]
    parameter int MEM_TIMEOUT = 15   // cycles a read may wait for mem_ack
) (
    input  logic               clk,
    input  logic               reset,          // synchronous, active low
    input  logic [INSTR_W-1:0] instr,
    input  logic               Zflag,
    input  logic               mem_ack,
    output logic [2:0]         ALU_Operation,
    output logic [3:0]         bus_sel,
    output logic               mem_read,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               ac_load,
    output logic               reg_wr,
    output logic               z_out,
    output logic               halt,
    output logic               bus_error
);

    // The decoder hard-wires the 4+4 instruction split. A datapath narrower
    // than one bit makes no sense. Reject either case at elaboration.
    if (reg_width < 1 || INSTR_W != 8 || MEM_TIMEOUT < 1) begin : g_bad_params
        $error("control_sequencer: unsupported parameter set");
    end

    // Sequencer states
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_STORE  = 3'd4,
        S_OPND   = 3'd5,
        S_HALTED = 3'd6
    } state_e;

    // Instruction opcodes. Codes A-E are unassigned and fall through as NOP.
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDAC = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_MUL  = 4'h4,
        OP_INC  = 4'h5,
        OP_CLR  = 4'h6,
        OP_STAC = 4'h7,
        OP_JMP  = 4'h8,
        OP_JMPZ = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    // ALU function codes as the ALU expects them
    typedef enum logic [2:0] {
        ALU_IDLE  = 3'b000,
        ALU_PASS  = 3'b001,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_MUL   = 3'b100,
        ALU_PLUS1 = 3'b101,
        ALU_ZERO  = 3'b110
    } alu_op_e;

    // The bus select value that routes the accumulator onto the bus
    localparam logic [3:0] AC_SEL = 4'd15;

    // Wide enough to hold 0 .. MEM_TIMEOUT-1 waiting cycles
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    // Map an ALU-class opcode to its ALU function. All other opcodes map to IDLE.
    function automatic logic [2:0] alu_map(input logic [3:0] op);
        case (op)
            OP_LDAC: alu_map = ALU_PASS;
            OP_ADD:  alu_map = ALU_ADD;
            OP_SUB:  alu_map = ALU_SUB;
            OP_MUL:  alu_map = ALU_MUL;
            OP_INC:  alu_map = ALU_PLUS1;
            OP_CLR:  alu_map = ALU_ZERO;
            default: alu_map = ALU_IDLE;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // cycles spent waiting for mem_ack
    logic             z_q, z_d;          // architectural zero flag
    logic             berr_q, berr_d;    // sticky memory timeout indication

    logic [3:0] opcode;
    logic [3:0] reg_field;

    assign opcode    = instr[7:4];
    assign reg_field = instr[3:0];

    // State register, wait counter, zero flag and sticky bus error
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples its _d value from before the edge, whatever the statement order.
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            berr_q  <= berr_d;
        end
    end

    // Next-state, handshake and output decode
    always_comb begin
        // NOTE: every signal written here gets a default first. Any path that
        // did not assign one would otherwise infer a latch.
        state_d       = state_q;
        cnt_d         = '0;
        z_d           = z_q;
        berr_d        = berr_q;
        ALU_Operation = ALU_IDLE;
        bus_sel       = 4'd0;
        mem_read      = 1'b0;
        ir_load       = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        ac_load       = 1'b0;
        reg_wr        = 1'b0;
        z_out         = z_q;
        halt          = 1'b0;
        bus_error     = berr_q;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HALTED;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_LDAC, OP_ADD, OP_SUB,
                    OP_MUL, OP_INC, OP_CLR:  state_d = S_EXEC;
                    OP_STAC:                 state_d = S_STORE;
                    OP_JMP, OP_JMPZ:         state_d = S_OPND;
                    OP_HALT:                 state_d = S_HALTED;
                    default:                 state_d = S_FETCH;
                endcase
            end

            S_EXEC: begin
                ALU_Operation = alu_map(opcode);
                bus_sel       = reg_field;
                state_d       = S_WB;
            end

            S_WB: begin
                ALU_Operation = alu_map(opcode);
                bus_sel       = reg_field;
                ac_load       = 1'b1;
                // Only a subtraction updates the architectural zero flag
                if (opcode == OP_SUB) begin
                    z_d = Zflag;
                end
                state_d = S_FETCH;
            end

            S_STORE: begin
                bus_sel = AC_SEL;
                // Register 15 is not backed by storage, so its write is dropped
                reg_wr  = (reg_field != AC_SEL);
                state_d = S_FETCH;
            end

            S_OPND: begin
                mem_read = 1'b1;
                if (mem_ack) begin
                    if (opcode == OP_JMP || (opcode == OP_JMPZ && z_q)) begin
                        pc_load = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                    state_d = S_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HALTED;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HALTED: begin
                halt = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Hold every output quiet while reset is asserted. The datapath then
        // sees no strobes, even before the first reset edge has been sampled.
        if (!reset) begin
            ALU_Operation = ALU_IDLE;
            bus_sel       = 4'd0;
            mem_read      = 1'b0;
            ir_load       = 1'b0;
            pc_inc        = 1'b0;
            pc_load       = 1'b0;
            ac_load       = 1'b0;
            reg_wr        = 1'b0;
            z_out         = 1'b0;
            halt          = 1'b0;
            bus_error     = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. The stimulus side walks
// instructions at the transaction level (fetch wait, decode, execute phase).
// It queues the output vector the specification requires for every cycle.
// A negedge monitor pops the queue and compares it against the DUT.

module tb_control_sequencer;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic       Zflag;
    logic       mem_ack;
    logic [2:0] ALU_Operation;
    logic [3:0] bus_sel;
    logic       mem_read, ir_load, pc_inc, pc_load, ac_load, reg_wr;
    logic       z_out, halt, bus_error;

    always #5 clk = ~clk;

    control_sequencer #(
        .reg_width  (12),
        .INSTR_W    (8),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .Zflag        (Zflag),
        .mem_ack      (mem_ack),
        .ALU_Operation(ALU_Operation),
        .bus_sel      (bus_sel),
        .mem_read     (mem_read),
        .ir_load      (ir_load),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .ac_load      (ac_load),
        .reg_wr       (reg_wr),
        .z_out        (z_out),
        .halt         (halt),
        .bus_error    (bus_error)
    );

    typedef struct packed {
        logic [2:0] alu;
        logic [3:0] bsel;
        logic       rd, ir, pi, pl, ac, wr, z, h, be;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    obs_t act;
    int   checks_n = 0;
    int   errors_n = 0;
    bit   mz;   // model of the architectural zero flag
    bit   mbe;  // model of the sticky bus error
    bit   t_ok;

    assign act = {ALU_Operation, bus_sel, mem_read, ir_load, pc_inc, pc_load,
                  ac_load, reg_wr, z_out, halt, bus_error};

    task automatic check(input string name, input obs_t a, input obs_t e);
        checks_n++;
        if (a !== e) begin
            errors_n++;
            $display("FAIL %s @%0t: got alu=%b bus=%0d rd,ir,pi,pl,ac,wr,z,h,be=%b required alu=%b bus=%0d rd,ir,pi,pl,ac,wr,z,h,be=%b",
                     name, $time, a.alu, a.bsel, a[8:0], e.alu, e.bsel, e[8:0]);
        end
    endtask

    // Monitor: one expected vector per driven cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check(mon_e.tag, act, mon_e.v);
        end
    end

    // ALU function for each opcode, as listed in the instruction set
    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            4'h1: return 3'b001;  // LDAC -> Pass
            4'h2: return 3'b010;  // ADD
            4'h3: return 3'b011;  // SUB
            4'h4: return 3'b100;  // MUL
            4'h5: return 3'b101;  // INC  -> Plus1
            4'h6: return 3'b110;  // CLR  -> Zero
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Outputs of a cycle with no activity: only the visible flags
    function automatic obs_t idle_obs();
        obs_t o;
        o    = '0;
        o.z  = mz;
        o.be = mbe;
        return o;
    endfunction

    // Apply inputs for one cycle, queue its expected outputs, advance a clock
    task automatic drive(input obs_t e, input logic ack, input logic zf, input string tag);
        exp_t x;
        mem_ack = ack;
        Zflag   = zf;
        x.v     = e;
        x.tag   = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        mz  = 1'b0;
        mbe = 1'b0;
        for (int i = 0; i < n; i++) begin
            reset = 1'b0;
            drive(idle_obs(), rbit(), rbit(), "reset");
        end
        reset = 1'b1;
    endtask

    // Memory read that waits w cycles before acking. With w >= TMO it times out.
    task automatic mem_wait(input int w, input obs_t ack_exp, input string tag, output bit ok);
        obs_t e;
        ok = 1'b1;
        for (int i = 0; i < w && i < TMO; i++) begin
            e    = idle_obs();
            e.rd = 1'b1;
            drive(e, 1'b0, rbit(), tag);
        end
        if (w >= TMO) begin
            mbe = 1'b1;
            ok  = 1'b0;
        end else begin
            drive(ack_exp, 1'b1, rbit(), tag);
        end
    endtask

    // Sequencer stopped: halt stays high until reset
    task automatic halt_tail();
        obs_t e;
        for (int i = 0; i < 4; i++) begin
            e   = idle_obs();
            e.h = 1'b1;
            drive(e, rbit(), rbit(), "halted");
        end
        do_reset(2);
    endtask

    task automatic run_instr(input logic [7:0] ins, input int wf, input int wo, input logic zf_wb);
        obs_t       e;
        bit         ok;
        logic [3:0] op;
        logic [3:0] r;
        instr = ins;
        op    = ins[7:4];
        r     = ins[3:0];
        e     = idle_obs();
        e.rd  = 1'b1;
        e.ir  = 1'b1;
        e.pi  = 1'b1;
        mem_wait(wf, e, "fetch", ok);
        if (!ok) begin
            halt_tail();
            return;
        end
        drive(idle_obs(), rbit(), rbit(), "decode");
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                e      = idle_obs();
                e.alu  = alu_of(op);
                e.bsel = r;
                drive(e, rbit(), rbit(), "exec");
                e.ac   = 1'b1;
                drive(e, rbit(), zf_wb, "wb");
                if (op == 4'h3) mz = zf_wb;
            end
            4'h7: begin
                e      = idle_obs();
                e.bsel = 4'd15;
                e.wr   = (r != 4'd15);
                drive(e, rbit(), rbit(), "store");
            end
            4'h8, 4'h9: begin
                e    = idle_obs();
                e.rd = 1'b1;
                if (op == 4'h8 || mz) e.pl = 1'b1;
                else                  e.pi = 1'b1;
                mem_wait(wo, e, "opnd", ok);
                if (!ok) halt_tail();
            end
            4'hF: halt_tail();
            default: ;
        endcase
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 39));
        if (r == 0) return TMO;
        if (r == 1) return TMO - 1;
        return int'($urandom_range(0, 3));
    endfunction

    // Watchdog: the run must finish long before this
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks_n, errors_n);
        $fatal(1);
    end

    initial begin
        obs_t e;
        reset   = 1'b0;
        instr   = 8'h00;
        mem_ack = 1'b0;
        Zflag   = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Reset held two cycles while an operand read is outstanding, with z set
        run_instr(8'h35, 0, 0, 1'b1);
        instr = 8'h80;
        e     = idle_obs();
        e.rd  = 1'b1;
        e.ir  = 1'b1;
        e.pi  = 1'b1;
        mem_wait(1, e, "t1_fetch", t_ok);
        drive(idle_obs(), 1'b0, rbit(), "t1_decode");
        e    = idle_obs();
        e.rd = 1'b1;
        drive(e, 1'b0, rbit(), "t1_opnd");
        drive(e, 1'b0, rbit(), "t1_opnd");
        do_reset(2);

        // ADD r3, SUB setting z, then JMPZ taken
        run_instr(8'h23, 0, 0, 1'b1);
        run_instr(8'h35, 0, 0, 1'b1);
        run_instr(8'h91, 0, 0, 1'b0);
        // SUB clearing z, JMPZ falls through, JMP always loads
        run_instr(8'h35, 1, 0, 1'b0);
        run_instr(8'h91, 0, 2, 1'b0);
        run_instr(8'h80, 0, 0, 1'b0);
        // Stores, including the dropped write to register 15
        run_instr(8'h74, 0, 0, 1'b0);
        run_instr(8'h7F, 2, 0, 1'b0);
        // Fetch timeout, ack on the last allowed cycle, operand timeout
        run_instr(8'h23, TMO, 0, 1'b0);
        run_instr(8'h23, TMO - 1, 0, 1'b1);
        run_instr(8'h91, 0, TMO, 1'b0);
        // Illegal opcode behaves as NOP, then HALT
        run_instr(8'hB2, 0, 0, 1'b0);
        run_instr(8'hF0, 0, 0, 1'b0);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            run_instr(8'($urandom_range(0, 255)), rand_wait(), rand_wait(), rbit());
        end

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            errors_n++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule
